// File: rtl/hub75_capture.sv
// hub75_capture: HUB75 receive side. Synchronizes the panel pins, rebuilds each shifted row in a
// ping-pong line buffer and replays it as a pixel stream. Optional on-time counter: HUB75_CAPTURE_ONTIME_EN.
module hub75_capture #(
  parameter int COLS        = 32,
  parameter int ROWBITS     = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_sclk,
  input  logic               in_latch,
  input  logic               in_blank,
  input  logic [ROWBITS-1:0] in_addr,
  input  logic [2:0]         in_rgb1,
  input  logic [2:0]         in_rgb2,
  output logic               pix_valid,
  output logic [4:0]         pix_col,
  output logic [ROWBITS-1:0] pix_row,
  output logic [2:0]         pix_rgb1,
  output logic [2:0]         pix_rgb2,
  output logic               row_done,
  output logic               frame_start,
`ifdef HUB75_CAPTURE_ONTIME_EN
  output logic [15:0]        on_time,
`endif
  output logic               overrun
);

  // state   | meaning
  // S_IDLE  | waiting for a latch
  // S_DRAIN | replaying line[drain_bank], one pixel per clk
  // S_DONE  | last pixel sent, pulse row_done
  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_DONE} state_t;

  localparam int         AW     = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [5:0] COLS_C = 6'(COLS);
`ifdef HUB75_CAPTURE_ONTIME_EN
  localparam int         NB     = ROWBITS + 9;
`else
  localparam int         NB     = ROWBITS + 8;
`endif

  logic [NB-1:0] w_pins;
`ifdef HUB75_CAPTURE_ONTIME_EN
  assign w_pins = {in_blank, in_sclk, in_latch, in_addr, in_rgb1, in_rgb2};
`else
  logic w_unused_blank;
  assign w_unused_blank = in_blank;
  assign w_pins = {in_sclk, in_latch, in_addr, in_rgb1, in_rgb2};
`endif

  // Data and strobes share one synchronizer chain so they stay aligned with the edge detect.
  logic [NB-1:0] r_sync [SYNC_STAGES];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= w_pins;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  logic [NB-1:0]      w_s;
  logic               w_s_sclk, w_s_latch;
  logic [ROWBITS-1:0] w_s_addr;
  logic [2:0]         w_s_rgb1, w_s_rgb2;
  assign w_s       = r_sync[SYNC_STAGES-1];
  assign w_s_sclk  = w_s[ROWBITS+7];
  assign w_s_latch = w_s[ROWBITS+6];
  assign w_s_addr  = w_s[ROWBITS+5:6];
  assign w_s_rgb1  = w_s[5:3];
  assign w_s_rgb2  = w_s[2:0];

  logic r_sclk_d, r_latch_d;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sclk_d  <= 1'b0;
      r_latch_d <= 1'b0;
    end else begin
      r_sclk_d  <= w_s_sclk;
      r_latch_d <= w_s_latch;
    end
  end

  logic       w_sclk_rise, w_latch_rise, w_shift_ok;
  logic [5:0] r_shift_cnt, w_cnt_next;
  logic       r_wr_bank;
  assign w_sclk_rise  = w_s_sclk & ~r_sclk_d;
  assign w_latch_rise = w_s_latch & ~r_latch_d;
  assign w_shift_ok   = w_sclk_rise && (r_shift_cnt != COLS_C);
  assign w_cnt_next   = w_shift_ok ? r_shift_cnt + 6'd1 : r_shift_cnt;

  logic [5:0] r_line [2][COLS];
  always_ff @(posedge clk) begin
    if (w_shift_ok) r_line[r_wr_bank][r_shift_cnt[AW-1:0]] <= {w_s_rgb1, w_s_rgb2};
  end

  state_t             r_state;
  logic               r_drain_bank, r_fs_pend;
  logic [5:0]         r_drain_len;
  logic [4:0]         r_idx;
  logic [ROWBITS-1:0] r_drain_row, r_last_row;
  logic [5:0]         w_rd;
  logic               w_last;
  assign w_rd   = r_line[r_drain_bank][r_idx[AW-1:0]];
  assign w_last = ({1'b0, r_idx} == (r_drain_len - 6'd1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_shift_cnt  <= '0;
      r_wr_bank    <= 1'b0;
      r_drain_bank <= 1'b0;
      r_drain_len  <= '0;
      r_drain_row  <= '0;
      r_last_row   <= '1;
      r_fs_pend    <= 1'b0;
      r_idx        <= '0;
      pix_valid    <= 1'b0;
      pix_col      <= '0;
      pix_row      <= '0;
      pix_rgb1     <= '0;
      pix_rgb2     <= '0;
      row_done     <= 1'b0;
      frame_start  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      pix_valid   <= 1'b0;
      row_done    <= 1'b0;
      frame_start <= 1'b0;
      if (w_sclk_rise) begin
        if (r_shift_cnt == COLS_C) overrun <= 1'b1;
        else                       r_shift_cnt <= r_shift_cnt + 6'd1;
      end
      if (r_state == S_DONE) row_done <= 1'b1;
      if (w_latch_rise) begin
        // The shift of this same cycle (if any) belongs to the row being latched.
        r_drain_bank <= r_wr_bank;
        r_wr_bank    <= ~r_wr_bank;
        r_drain_len  <= w_cnt_next;
        r_shift_cnt  <= '0;
        r_drain_row  <= w_s_addr;
        r_last_row   <= w_s_addr;
        r_fs_pend    <= (w_s_addr == '0) && (r_last_row != '0);
        r_idx        <= '0;
        r_state      <= S_DRAIN;
        if (r_state == S_DRAIN) overrun <= 1'b1;
      end else begin
        case (r_state)
          S_DRAIN: begin
            if (r_drain_len == 6'd0) begin
              row_done    <= 1'b1;
              frame_start <= r_fs_pend;
              r_state     <= S_IDLE;
            end else begin
              pix_valid   <= 1'b1;
              pix_col     <= r_idx;
              pix_row     <= r_drain_row;
              pix_rgb1    <= w_rd[5:3];
              pix_rgb2    <= w_rd[2:0];
              frame_start <= (r_idx == 5'd0) && r_fs_pend;
              if (w_last) r_state <= S_DONE;
              else        r_idx   <= r_idx + 5'd1;
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef HUB75_CAPTURE_ONTIME_EN
  logic        w_s_blank;
  logic [15:0] r_on_cnt;
  assign w_s_blank = w_s[ROWBITS+8];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_on_cnt <= '0;
      on_time  <= '0;
    end else if (w_latch_rise) begin
      on_time  <= r_on_cnt;
      r_on_cnt <= '0;
    end else if (!w_s_blank && (r_on_cnt != 16'hFFFF)) begin
      r_on_cnt <= r_on_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hub75_capture.sv
// Bench for hub75_capture: table-driven rows, randomized rows against a queue model,
// and hand sequences for latency, reset mid-drain and latch mid-drain.
module tb_hub75_capture;
  localparam int COLS = 32;
  localparam int SYNC = 2;

  logic       clk = 1'b0, reset_n = 1'b0;
  logic       in_sclk = 1'b0, in_latch = 1'b0, in_blank = 1'b1;
  logic [4:0] in_addr = '0;
  logic [2:0] in_rgb1 = '0, in_rgb2 = '0;
  logic       pix_valid, row_done, frame_start, overrun;
  logic [4:0] pix_col, pix_row;
  logic [2:0] pix_rgb1, pix_rgb2;

  always #5 clk = ~clk;

  hub75_capture #(.COLS(COLS), .ROWBITS(5), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset_n(reset_n), .in_sclk(in_sclk), .in_latch(in_latch), .in_blank(in_blank),
    .in_addr(in_addr), .in_rgb1(in_rgb1), .in_rgb2(in_rgb2), .pix_valid(pix_valid),
    .pix_col(pix_col), .pix_row(pix_row), .pix_rgb1(pix_rgb1), .pix_rgb2(pix_rgb2),
    .row_done(row_done), .frame_start(frame_start), .overrun(overrun));

  typedef struct packed {logic [4:0] col; logic [4:0] row; logic [2:0] r1; logic [2:0] r2; logic fs;} pix_t;
  typedef struct {logic [4:0] addr; int n; bit rnd; bit exp_fs; bit exp_ovr;} vec_t;

  int   checks = 0, failures = 0;
  pix_t got_q[$];
  int   done_cnt = 0;
  logic last_done_fs = 1'b0;
  logic [4:0] mdl_last_row = 5'h1F;
  bit   mdl_ovr = 1'b0;

  always @(posedge clk) begin
    #1;
    if (pix_valid) got_q.push_back({pix_col, pix_row, pix_rgb1, pix_rgb2, frame_start});
    if (row_done) begin
      done_cnt++;
      last_done_fs = frame_start;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic shift_px(input logic [2:0] r1, input logic [2:0] r2);
    @(negedge clk); in_rgb1 = r1; in_rgb2 = r2;
    repeat (2) @(negedge clk); in_sclk = 1'b1;
    repeat (2) @(negedge clk); in_sclk = 1'b0;
  endtask

  task automatic do_latch(input logic [4:0] a);
    @(negedge clk); in_addr = a;
    repeat (2) @(negedge clk); in_latch = 1'b1;
    repeat (2) @(negedge clk); in_latch = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int i = 0;
    while (done_cnt == d0 && i < 300) begin
      @(negedge clk);
      i++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic send_row(input logic [4:0] addr, input int n, input bit rnd,
                          input bit exp_fs, input bit exp_ovr, input string nm);
    logic [2:0] a1[$], a2[$];
    logic [2:0] v1, v2;
    pix_t e;
    int d0, nexp;
    got_q.delete();
    d0 = done_cnt;
    for (int i = 0; i < n; i++) begin
      v1 = rnd ? 3'($urandom) : 3'(i);
      v2 = rnd ? 3'($urandom) : ~3'(i);
      a1.push_back(v1);
      a2.push_back(v2);
      shift_px(v1, v2);
    end
    do_latch(addr);
    wait_done(d0);
    nexp = (n > COLS) ? COLS : n;
    check({nm, " row_done"}, done_cnt - d0, 1);
    check({nm, " npix"}, got_q.size(), nexp);
    for (int i = 0; i < got_q.size() && i < nexp; i++) begin
      e = '{col: 5'(i), row: addr, r1: a1[i], r2: a2[i], fs: (i == 0) && exp_fs};
      check($sformatf("%s pix%0d", nm, i), 32'(got_q[i]), 32'(e));
    end
    check({nm, " done_fs"}, last_done_fs, (n == 0) ? exp_fs : 1'b0);
    check({nm, " overrun"}, overrun, exp_ovr);
    mdl_last_row = addr;
    mdl_ovr = mdl_ovr | (n > COLS);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[9];
    int n, d0, k;
    logic [4:0] ra;
    int rn;
    bit rfs;
    pix_t e;
    logic [2:0] aa1[32], aa2[32], bb1[3], bb2[3];

    tbl[0] = '{5'd5, 32, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{5'd3,  8, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{5'd4,  1, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{5'd0, 32, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{5'd0,  5, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{5'd2,  0, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{5'd0,  0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{5'd7, 33, 1'b0, 1'b0, 1'b1};
    tbl[8] = '{5'd1,  4, 1'b1, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    check("rst pix_valid", pix_valid, 0);
    check("rst row_done", row_done, 0);
    check("rst frame_start", frame_start, 0);
    check("rst overrun", overrun, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Pin-to-first-pixel latency
    got_q.delete();
    d0 = done_cnt;
    shift_px(3'd1, 3'd6);
    shift_px(3'd2, 3'd5);
    @(negedge clk); in_addr = 5'd9;
    repeat (2) @(negedge clk); in_latch = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!pix_valid && n < 20);
    check("latency pix", n, SYNC + 2);
    @(negedge clk); in_latch = 1'b0;
    wait_done(d0);
    check("lat npix", got_q.size(), 2);
    e = '{col: 5'd0, row: 5'd9, r1: 3'd1, r2: 3'd6, fs: 1'b0};
    if (got_q.size() > 0) check("lat pix0", 32'(got_q[0]), 32'(e));
    e = '{col: 5'd1, row: 5'd9, r1: 3'd2, r2: 3'd5, fs: 1'b0};
    if (got_q.size() > 1) check("lat pix1", 32'(got_q[1]), 32'(e));
    check("lat row_done", done_cnt - d0, 1);

    // Empty row: row_done with the same latency a first pixel would have
    got_q.delete();
    d0 = done_cnt;
    @(negedge clk); in_addr = 5'd12;
    repeat (2) @(negedge clk); in_latch = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!row_done && n < 20);
    check("latency empty", n, SYNC + 2);
    @(negedge clk); in_latch = 1'b0;
    repeat (5) @(negedge clk);
    check("empty npix", got_q.size(), 0);
    check("empty row_done", done_cnt - d0, 1);
    mdl_last_row = 5'd12;

    for (int t = 0; t < 9; t++)
      send_row(tbl[t].addr, tbl[t].n, tbl[t].rnd, tbl[t].exp_fs, tbl[t].exp_ovr, $sformatf("tbl%0d", t));

    // Reset asserted mid-drain
    got_q.delete();
    d0 = done_cnt;
    for (int i = 0; i < 32; i++) shift_px(3'(i), ~3'(i));
    do_latch(5'd6);
    repeat (4) @(negedge clk);
    check("drain active", pix_valid, 1);
    reset_n = 1'b0;
    #1;
    check("rst mid pix_valid", pix_valid, 0);
    check("rst mid row_done", row_done, 0);
    check("rst mid overrun", overrun, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    mdl_last_row = 5'h1F;
    mdl_ovr = 1'b0;
    repeat (40) @(negedge clk);
    check("rst no row_done", done_cnt - d0, 0);
    send_row(5'd0, 4, 1'b1, 1'b1, 1'b0, "post_reset");

    for (int r = 0; r < 16; r++) begin
      ra  = 5'($urandom_range(0, 3));
      rn  = $urandom_range(0, 34);
      rfs = (ra == 5'd0) && (mdl_last_row != 5'd0);
      send_row(ra, rn, 1'b1, rfs, mdl_ovr | (rn > COLS), $sformatf("rnd%0d", r));
    end

    // Next row shifted during the drain, then latched before the drain finishes
    got_q.delete();
    d0 = done_cnt;
    for (int i = 0; i < 32; i++) begin
      aa1[i] = 3'($urandom); aa2[i] = 3'($urandom);
      shift_px(aa1[i], aa2[i]);
    end
    do_latch(5'd10);
    for (int i = 0; i < 3; i++) begin
      bb1[i] = 3'($urandom); bb2[i] = 3'($urandom);
      shift_px(bb1[i], bb2[i]);
    end
    do_latch(5'd11);
    wait_done(d0);
    check("middrain row_done", done_cnt - d0, 1);
    k = got_q.size() - 3;
    check("middrain cut", (k >= 1 && k < 32), 1);
    for (int i = 0; i < k && i < 32; i++) begin
      e = '{col: 5'(i), row: 5'd10, r1: aa1[i], r2: aa2[i], fs: 1'b0};
      check($sformatf("middrain A%0d", i), 32'(got_q[i]), 32'(e));
    end
    for (int j = 0; j < 3; j++) begin
      e = '{col: 5'(j), row: 5'd11, r1: bb1[j], r2: bb2[j], fs: 1'b0};
      if (k + j >= 0 && k + j < got_q.size())
        check($sformatf("middrain B%0d", j), 32'(got_q[k + j]), 32'(e));
    end
    check("middrain overrun", overrun, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
